// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32IM pipeline register file and its helpers.
package rv32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGS_DEF = 32;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// ID/WB-side bus of the multi-port register file: reads, write-back and issue.
interface reg_file_mp_if #(
  parameter int XLEN  = rv32_pkg::XLEN_DEF,
  parameter int DEPTH = rv32_pkg::REGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                READY;
  logic [NRD*AW-1:0]   RD_ADDR;
  logic [NRD*XLEN-1:0] RD_DATA;
  logic [NRD-1:0]      RD_BUSY;
  logic                WR_EN;
  logic [AW-1:0]       WR_ADDR;
  logic [XLEN-1:0]     WR_DATA;
  logic                ISSUE_EN;
  logic [AW-1:0]       ISSUE_ADDR;

  modport master (
    input  READY, RD_DATA, RD_BUSY,
    output RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ISSUE_EN, ISSUE_ADDR
  );

  modport slave (
    output READY, RD_DATA, RD_BUSY,
    input  RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ISSUE_EN, ISSUE_ADDR
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set on issue, cleared on write-back, set wins on collision.
module rf_scoreboard #(
  parameter int DEPTH = rv32_pkg::REGS_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [DEPTH-1:0] busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      // Applied after the clear so a new producer supersedes the completing one.
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with write bypass, zero register,
// busy scoreboard and a one-entry-per-cycle clear sequence after reset.
module reg_file_mp
  import rv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = REGS_DEF,
  parameter int NRD   = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  reg_file_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

  rf_state_t       state_q, state_d;
  logic [AW:0]     clr_ptr_q, clr_ptr_d;
  logic [XLEN-1:0] regs_q [DEPTH];
  logic            run;
  logic            clr_we;
  logic            wr_ok;
  logic [DEPTH-1:0] busy;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      RF_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == CLR_LAST) state_d = RF_RUN;
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_CLEAR;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      RF_CLEAR: clr_we = 1'b1;
      RF_RUN:   run    = 1'b1;
      default:  clr_we = 1'b0;
    endcase
  end

  assign bus.READY = run;
  assign wr_ok     = run && !RESET && bus.WR_EN && (bus.WR_ADDR != '0);

  always_ff @(posedge CLK) begin
    if (clr_we)     regs_q[clr_ptr_q[AW-1:0]] <= '0;
    else if (wr_ok) regs_q[bus.WR_ADDR]       <= bus.WR_DATA;
  end

  rf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .CLK        (CLK),
    .RESET      (RESET),
    .en_i       (run),
    .set_en_i   (bus.ISSUE_EN && (bus.ISSUE_ADDR != '0)),
    .set_addr_i (bus.ISSUE_ADDR),
    .clr_en_i   (bus.WR_EN && (bus.WR_ADDR != '0)),
    .clr_addr_i (bus.WR_ADDR),
    .busy_o     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = bus.RD_ADDR[i*AW +: AW];
    assign hit  = bus.WR_EN && (bus.WR_ADDR == addr);
    assign bus.RD_DATA[i*XLEN +: XLEN] = (!run || addr == '0) ? '0 :
                                         hit ? bus.WR_DATA : regs_q[addr];
    assign bus.RD_BUSY[i] = run && busy[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: clear sequence, read/write, bypass,
// scoreboard, reset during clear, and a wide/shallow/4-port instance.
`timescale 1ns/1ps
module tb_reg_file_mp;
  import rv32_pkg::*;

  logic CLK = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_file_mp_if #(.XLEN(32), .DEPTH(32), .NRD(2)) ifa ();
  reg_file_mp_if #(.XLEN(64), .DEPTH(16), .NRD(4)) ifb ();

  reg_file_mp #(.XLEN(32), .DEPTH(32), .NRD(2)) dut_a (
    .CLK(CLK), .RESET(rst_a), .bus(ifa.slave));
  reg_file_mp #(.XLEN(64), .DEPTH(16), .NRD(4)) dut_b (
    .CLK(CLK), .RESET(rst_b), .bus(ifb.slave));

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic idle_a();
    ifa.WR_EN = 0; ifa.WR_ADDR = 0; ifa.WR_DATA = 0;
    ifa.ISSUE_EN = 0; ifa.ISSUE_ADDR = 0;
  endtask

  // Counts edges until READY; optionally pokes a write+issue to x1 at edge 5.
  task automatic wait_ready_a(input bit inject, output int cnt, output bit bad);
    cnt = 0; bad = 0;
    while (ifa.READY !== 1'b1 && cnt < 100) begin
      if (ifa.RD_DATA !== '0 || ifa.RD_BUSY !== '0) bad = 1;
      cyc(); cnt++;
      if (inject && cnt == 5) begin
        ifa.WR_EN = 1; ifa.WR_ADDR = 5'd1; ifa.WR_DATA = 32'h1111_2222;
        ifa.ISSUE_EN = 1; ifa.ISSUE_ADDR = 5'd1; #1;
        if (ifa.RD_DATA !== '0 || ifa.RD_BUSY !== '0) bad = 1;
      end
      if (inject && cnt == 6) idle_a();
    end
  endtask

  task automatic test_reset();
    int cnt; bit bad;
    idle_a(); ifa.RD_ADDR = {5'd5, 5'd0};
    rst_a = 1; cyc();
    checks++; if (ifa.READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ifa.READY); end
    checks++; if (ifa.RD_DATA !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", ifa.RD_DATA); end
    checks++; if (ifa.RD_BUSY !== 2'b00) begin failures++; $display("FAIL reset_rd_busy got=%b exp=00", ifa.RD_BUSY); end
    rst_a = 0;
    wait_ready_a(0, cnt, bad);
    checks++; if (cnt != 32) begin failures++; $display("FAIL clear_len got=%0d exp=32", cnt); end
    checks++; if (bad) begin failures++; $display("FAIL clear_reads_zero got=nonzero exp=0"); end
  endtask

  task automatic test_write_read();
    ifa.WR_EN = 1; ifa.WR_ADDR = 5'd5; ifa.WR_DATA = 32'hDEAD_BEEF;
    cyc(); idle_a();
    ifa.RD_ADDR = {5'd0, 5'd5}; #1;
    checks++; if (ifa.RD_DATA[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_x5 got=%h exp=deadbeef", ifa.RD_DATA[31:0]); end
    checks++; if (ifa.RD_DATA[63:32] !== 32'h0) begin failures++; $display("FAIL rd_x0 got=%h exp=0", ifa.RD_DATA[63:32]); end
    ifa.WR_EN = 1; ifa.WR_ADDR = 5'd0; ifa.WR_DATA = 32'h0000_1234;
    ifa.RD_ADDR = {5'd0, 5'd0};
    cyc(); idle_a(); #1;
    checks++; if (ifa.RD_DATA !== 64'h0) begin failures++; $display("FAIL wr_x0_dropped got=%h exp=0", ifa.RD_DATA); end
  endtask

  task automatic test_bypass();
    ifa.RD_ADDR = {5'd7, 5'd7}; #1;
    checks++; if (ifa.RD_DATA !== 64'h0) begin failures++; $display("FAIL x7_before got=%h exp=0", ifa.RD_DATA); end
    ifa.WR_EN = 1; ifa.WR_ADDR = 5'd7; ifa.WR_DATA = 32'hA5A5_A5A5; #1;
    checks++; if (ifa.RD_DATA !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL bypass_both got=%h exp=a5a5a5a5a5a5a5a5", ifa.RD_DATA); end
    cyc(); idle_a(); #1;
    checks++; if (ifa.RD_DATA !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL x7_stored got=%h exp=a5a5a5a5a5a5a5a5", ifa.RD_DATA); end
  endtask

  task automatic test_scoreboard();
    ifa.RD_ADDR = {5'd0, 5'd3};
    ifa.ISSUE_EN = 1; ifa.ISSUE_ADDR = 5'd3; #1;
    checks++; if (ifa.RD_BUSY !== 2'b00) begin failures++; $display("FAIL busy_same_cycle got=%b exp=00", ifa.RD_BUSY); end
    cyc(); idle_a(); #1;
    checks++; if (ifa.RD_BUSY !== 2'b01) begin failures++; $display("FAIL busy_x3_set got=%b exp=01", ifa.RD_BUSY); end
    ifa.WR_EN = 1; ifa.WR_ADDR = 5'd3; ifa.WR_DATA = 32'h3333_3333; #1;
    checks++; if (ifa.RD_BUSY !== 2'b00) begin failures++; $display("FAIL busy_wb_bypass got=%b exp=00", ifa.RD_BUSY); end
    cyc(); idle_a(); #1;
    checks++; if (ifa.RD_BUSY !== 2'b00) begin failures++; $display("FAIL busy_x3_cleared got=%b exp=00", ifa.RD_BUSY); end
    ifa.RD_ADDR = {5'd0, 5'd9};
    ifa.ISSUE_EN = 1; ifa.ISSUE_ADDR = 5'd9;
    ifa.WR_EN = 1; ifa.WR_ADDR = 5'd9; ifa.WR_DATA = 32'h9999_9999;
    cyc(); idle_a(); #1;
    checks++; if (ifa.RD_BUSY !== 2'b01) begin failures++; $display("FAIL busy_set_wins got=%b exp=01", ifa.RD_BUSY); end
    ifa.ISSUE_EN = 1; ifa.ISSUE_ADDR = 5'd0;
    cyc(); idle_a(); ifa.RD_ADDR = {5'd9, 5'd0}; #1;
    checks++; if (ifa.RD_BUSY !== 2'b10) begin failures++; $display("FAIL busy_x0_never got=%b exp=10", ifa.RD_BUSY); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt; bit bad;
    rst_a = 1; cyc(); rst_a = 0;
    for (int i = 0; i < 10; i++) begin
      ifa.WR_EN = (i % 2 == 0); ifa.WR_ADDR = 5'd2; ifa.WR_DATA = 32'hBAD0_0000;
      cyc();
    end
    idle_a();
    rst_a = 1; cyc();
    checks++; if (ifa.READY !== 1'b0) begin failures++; $display("FAIL midclr_ready got=%b exp=0", ifa.READY); end
    rst_a = 0;
    ifa.RD_ADDR = {5'd9, 5'd1};
    wait_ready_a(1, cnt, bad);
    checks++; if (cnt != 32) begin failures++; $display("FAIL midclr_len got=%0d exp=32", cnt); end
    checks++; if (bad) begin failures++; $display("FAIL midclr_reads_zero got=nonzero exp=0"); end
    checks++; if (ifa.RD_DATA !== 64'h0) begin failures++; $display("FAIL midclr_wr_ignored got=%h exp=0", ifa.RD_DATA); end
    checks++; if (ifa.RD_BUSY !== 2'b00) begin failures++; $display("FAIL midclr_busy got=%b exp=00", ifa.RD_BUSY); end
    ifa.RD_ADDR = {5'd2, 5'd7}; #1;
    checks++; if (ifa.RD_DATA !== 64'h0) begin failures++; $display("FAIL midclr_x2_x7 got=%h exp=0", ifa.RD_DATA); end
  endtask

  task automatic test_param_sweep();
    int cnt;
    logic [63:0] vals [4];
    vals[0] = 64'h0123_4567_89AB_CDEF; vals[1] = 64'hFEDC_BA98_7654_3210;
    vals[2] = 64'hCAFE_F00D_0000_0001; vals[3] = 64'h8000_0000_0000_0042;
    ifb.WR_EN = 0; ifb.WR_ADDR = 0; ifb.WR_DATA = 0;
    ifb.ISSUE_EN = 0; ifb.ISSUE_ADDR = 0; ifb.RD_ADDR = '0;
    rst_b = 1; cyc(); rst_b = 0;
    cnt = 0;
    while (ifb.READY !== 1'b1 && cnt < 100) begin cyc(); cnt++; end
    checks++; if (cnt != 16) begin failures++; $display("FAIL sweep_clear_len got=%0d exp=16", cnt); end
    for (int i = 0; i < 4; i++) begin
      ifb.WR_EN = 1; ifb.WR_ADDR = 4'(i + 1); ifb.WR_DATA = vals[i];
      cyc();
    end
    ifb.WR_EN = 0;
    ifb.RD_ADDR = {4'd2, 4'd4, 4'd1, 4'd3}; #1;
    checks++; if (ifb.RD_DATA[0*64 +: 64] !== vals[2]) begin failures++; $display("FAIL sweep_p0 got=%h exp=%h", ifb.RD_DATA[0*64 +: 64], vals[2]); end
    checks++; if (ifb.RD_DATA[1*64 +: 64] !== vals[0]) begin failures++; $display("FAIL sweep_p1 got=%h exp=%h", ifb.RD_DATA[1*64 +: 64], vals[0]); end
    checks++; if (ifb.RD_DATA[2*64 +: 64] !== vals[3]) begin failures++; $display("FAIL sweep_p2 got=%h exp=%h", ifb.RD_DATA[2*64 +: 64], vals[3]); end
    checks++; if (ifb.RD_DATA[3*64 +: 64] !== vals[1]) begin failures++; $display("FAIL sweep_p3 got=%h exp=%h", ifb.RD_DATA[3*64 +: 64], vals[1]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid_clear();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the RV32IM pipeline's integer register file.
- Provides NRD combinational read ports, one synchronous write port with write-to-read bypass, and a hardwired zero register.
- Adds a per-register busy scoreboard for ID-stage hazard detection.
- Clearing is done by a sequenced, one-entry-per-cycle FSM rather than a bulk reset.
- Sits between the ID stage (reads, issue) and the WB stage (write).

Parameters:
- XLEN, 32: data width in bits.
- DEPTH, 32: number of architectural registers; must be a power of 2 and at least 2.
- AW, log2(DEPTH) = 5: register address width; derived, not overridable.
- NRD, 2: number of read ports, range 1..4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset; synchronous, active-high.
- READY  out  1  high when clearing is complete and the file is usable.
- RD_ADDR  in  NRD*AW  read addresses, packed; port i occupies [i*AW +: AW].
- RD_DATA  out  NRD*XLEN  read data, packed; port i occupies [i*XLEN +: XLEN].
- RD_BUSY  out  NRD  scoreboard busy flag of each read address.
- WR_EN  in  1  write enable (WB stage).
- WR_ADDR  in  AW  write address.
- WR_DATA  in  XLEN  write data.
- ISSUE_EN  in  1  marks ISSUE_ADDR as having a pending producer.
- ISSUE_ADDR  in  AW  destination register of the issued instruction.

Behaviour:
- FSM states: CLEAR and RUN.
- Reset:
  - RESET high at a rising edge: state <= CLEAR, clr_ptr <= 0, busy <= 0, READY <= 0.
  - Applies from any state, including mid-CLEAR; clearing restarts from entry 0.
  - Reset values: READY = 0, RD_DATA = 0, RD_BUSY = 0.
- CLEAR:
  - Each cycle: REG[clr_ptr] <= 0, clr_ptr++.
  - When clr_ptr == DEPTH-1 the entry is written, then state <= RUN and READY <= 1 on the same edge.
  - Clearing therefore takes exactly DEPTH cycles after RESET deasserts.
  - WR_EN and ISSUE_EN are ignored.
  - All RD_DATA = 0, all RD_BUSY = 0.
- RUN, write:
  - WR_EN && WR_ADDR != 0 -> REG[WR_ADDR] <= WR_DATA at the edge.
  - WR_ADDR == 0 is dropped silently.
- RUN, read (combinational, no added latency):
  - RD_ADDR_i == 0 -> RD_DATA_i = 0.
  - Else if WR_EN && WR_ADDR == RD_ADDR_i -> RD_DATA_i = WR_DATA (same-cycle bypass).
  - Else RD_DATA_i = REG[RD_ADDR_i].
  - Bypass applies to every port independently; several ports may read the same address.
- Scoreboard, RUN only:
  - ISSUE_EN && ISSUE_ADDR != 0 -> busy[ISSUE_ADDR] <= 1.
  - WR_EN && WR_ADDR != 0 -> busy[WR_ADDR] <= 0.
  - Same address, same cycle: set wins, because the new producer supersedes the old one.
  - busy[0] is constantly 0.
  - RD_BUSY_i = busy[RD_ADDR_i] && !(WR_EN && WR_ADDR == RD_ADDR_i); the completing write is visible through the bypass.
- Widths: no arithmetic beyond clr_ptr, which is AW+1 bits wide to avoid wrap before the terminal compare. Addresses are unsigned.
- No simulation delays.

Decomposition:
- Shared package rv32_pkg:
  - XLEN_DEF = 32, REGS_DEF = 32.
  - FSM state enum rf_state_t {RF_CLEAR, RF_RUN}.
- Sub-module rf_scoreboard:
  - Holds the busy vector plus set/clear priority logic.
  - Outputs the busy vector to the parent, which does per-port selection.

Test Plan:
- Reset then clear: assert RESET for 1 cycle, release -> READY stays 0 for 32 cycles and rises on cycle 32; all reads return 0 throughout.
- Write/read: write x5 = 0xDEADBEEF, next cycle read port 0 = x5, port 1 = x0 -> 0xDEADBEEF and 0x00000000; a write to x0 of 0x1234 -> x0 still reads 0.
- Bypass: in a single cycle WR_EN, WR_ADDR = 7, WR_DATA = 0xA5A5A5A5, with both read ports on x7 -> both ports return 0xA5A5A5A5 in that same cycle; REG[7] holds the value afterwards.
- Scoreboard: issue x3 -> RD_BUSY = 1 from the next cycle; WB writes x3 -> RD_BUSY = 0 in that cycle via bypass; issue and write of x9 in the same cycle -> busy[9] = 1 afterwards.
- Reset mid-clear: assert RESET at clear cycle 10 -> clr_ptr restarts at 0 and READY rises exactly 32 cycles after RESET deasserts; WR_EN pulses during CLEAR cause no change.
- Parameter sweep: XLEN = 64, DEPTH = 16, NRD = 4 -> the clear phase lasts 16 cycles and all 4 ports independently read distinct written values.
